// File: rtl/ps2_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_rx_if
// Scancode delivery bus between the PS/2 receiver and its consumer
// (keyboard MMIO / peripheral logic).
//   code_valid : receiver FIFO non-empty, code_data holds the head entry
//   code_ready : consumer accepts the head entry this cycle
//   code_data  : {release, extended, scancode[7:0]}
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface ps2_rx_if;
  logic       code_valid;
  logic       code_ready;
  logic [9:0] code_data;

  modport master (
    output code_valid,
    output code_data,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code_data,
    output code_ready
  );
endinterface : ps2_rx_if

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host receiver. Synchronises and deglitches the raw PS/2
// lines, decodes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and queues good scancodes in a first-word-fall-through FIFO.
//
// Optional feature macro: PS2_PREFIX_FOLD_EN
//   defined   : 0xE0 / 0xF0 prefix bytes are folded into bits [8]/[9] of the
//               next pushed scancode instead of being pushed themselves.
//   undefined : every good byte is pushed as {2'b00, byte}.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   code       if   ps2_rx_if.master : code_valid / code_ready / code_data
//   frame_err  out  one-cycle pulse: bad start, parity, stop bit or timeout
//   overflow   out  sticky: a good byte arrived while the FIFO was full
//   ovf_clear  in   clears overflow (a simultaneous set wins)
// -----------------------------------------------------------------------------
module ps2_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_if.master       code,
  output logic           frame_err,
  output logic           overflow,
  input  logic           ovf_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // True when the 8 data bits plus the parity bit carry odd parity.
  function automatic logic odd_parity_ok(input logic [7:0] byte_v, input logic par_v);
    return (^{byte_v, par_v}) == 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers and clock filter
  // ---------------------------------------------------------------------------
  logic          clk_meta_r;
  logic          clk_sync_r;
  logic          data_meta_r;
  logic          data_sync_r;
  logic          filt_r;
  logic          filt_d_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;

  // Two-flop synchronisers for both PS/2 pins, idle level 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN
  // consecutive samples that disagree with the current filtered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r     <= 1'b1;
      filt_d_r   <= 1'b1;
      filt_cnt_r <= '0;
    end else begin
      filt_d_r <= filt_r;
      if (clk_sync_r != filt_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_r     <= clk_sync_r;
          filt_cnt_r <= '0;
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  assign fall_s = filt_d_r & ~filt_r;

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  state_t        state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          par_r;
  logic [TW-1:0] to_cnt_r;
  logic          push_r;
  logic [9:0]    push_data_r;
`ifdef PS2_PREFIX_FOLD_EN
  logic          ext_r;
  logic          rel_r;
`endif

  // Frame FSM with inter-edge timeout; emits frame_err and a one-cycle push
  // request carrying the byte to queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      par_r       <= 1'b0;
      to_cnt_r    <= '0;
      frame_err   <= 1'b0;
      push_r      <= 1'b0;
      push_data_r <= 10'h000;
`ifdef PS2_PREFIX_FOLD_EN
      ext_r       <= 1'b0;
      rel_r       <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      push_r    <= 1'b0;

      if ((state_r == IDLE) || fall_s) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end

      if ((state_r != IDLE) && !fall_s && (to_cnt_r == TO_LAST)) begin
        // Line went quiet mid-frame: drop the partial byte.
        state_r   <= IDLE;
        frame_err <= 1'b1;
`ifdef PS2_PREFIX_FOLD_EN
        ext_r     <= 1'b0;
        rel_r     <= 1'b0;
`endif
      end else if (fall_s) begin
        case (state_r)
          IDLE: begin
            if (data_sync_r == 1'b0) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              frame_err <= 1'b1;
`ifdef PS2_PREFIX_FOLD_EN
              ext_r     <= 1'b0;
              rel_r     <= 1'b0;
`endif
            end
          end
          DATA: begin
            shift_r   <= {data_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end
          end
          PARITY: begin
            par_r   <= data_sync_r;
            state_r <= STOP;
          end
          STOP: begin
            state_r <= IDLE;
            if (data_sync_r && odd_parity_ok(shift_r, par_r)) begin
`ifdef PS2_PREFIX_FOLD_EN
              if (shift_r == 8'hE0) begin
                ext_r <= 1'b1;
              end else if (shift_r == 8'hF0) begin
                rel_r <= 1'b1;
              end else begin
                // Flags clear whether or not the push later overflows.
                push_r      <= 1'b1;
                push_data_r <= {rel_r, ext_r, shift_r};
                ext_r       <= 1'b0;
                rel_r       <= 1'b0;
              end
`else
              push_r      <= 1'b1;
              push_data_r <= {2'b00, shift_r};
`endif
            end else begin
              frame_err <= 1'b1;
`ifdef PS2_PREFIX_FOLD_EN
              ext_r     <= 1'b0;
              rel_r     <= 1'b0;
`endif
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO with registered valid/head outputs
  // ---------------------------------------------------------------------------
  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          valid_r;
  logic [9:0]    data_r;

  logic          pop_s;
  logic          full_s;
  logic          push_do_s;
  logic          drop_s;
  logic [AW:0]   wr_ptr_nxt_s;
  logic [AW:0]   rd_ptr_nxt_s;
  logic          valid_nxt_s;
  logic [9:0]    data_nxt_s;

  assign pop_s     = valid_r & code.code_ready;
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_do_s = push_r & (~full_s | pop_s);
  assign drop_s    = push_r & full_s & ~pop_s;

  // Next pointers and next head word, so valid and data can be registered.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(push_do_s);
    rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(pop_s);
    valid_nxt_s  = (wr_ptr_nxt_s != rd_ptr_nxt_s);
    data_nxt_s   = data_r;
    if (valid_nxt_s) begin
      // The new head is the word being written this cycle when the FIFO
      // would otherwise be empty after the pop.
      if (push_do_s && (rd_ptr_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
        data_nxt_s = push_data_r;
      end else begin
        data_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
      end
    end else begin
      data_nxt_s = data_r;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_do_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data_r;
    end
  end

  // FIFO pointers, registered head/valid and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      valid_r  <= 1'b0;
      data_r   <= 10'h000;
      overflow <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      valid_r  <= valid_nxt_s;
      data_r   <= data_nxt_s;
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

  assign code.code_valid = valid_r;
  assign code.code_data  = data_r;

endmodule : ps2_rx

// File: tb/tb_ps2_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx
// Self-checking bench for ps2_rx: PS/2 frames are bit-banged on the pins,
// expected scancodes are queued as frames are driven and compared when the
// consumer side pops them.
// -----------------------------------------------------------------------------
module tb_ps2_rx;

  localparam int TO_CYC = 20000;
  localparam int FLEN   = 4;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic ps2_clk   = 1'b1;
  logic ps2_data  = 1'b1;
  logic ovf_clear = 1'b0;
  logic frame_err;
  logic overflow;

  ps2_rx_if code_if ();

  ps2_rx #(
    .FIFO_DEPTH     (8),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code_if),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         errors    = 0;
  logic [9:0] exp_q[$];
  int         err_cnt   = 0;
  int         valid_hi  = 0;
  time        rise_time = 0;
  time        err_time  = 0;
  time        t_fall    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer-side monitor: scoreboard compare on every pop, plus event stamps.
  initial begin
    logic       prev_valid;
    logic [9:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) begin
          err_cnt++;
          err_time = $time;
        end
        if (code_if.code_valid) valid_hi++;
        if (code_if.code_valid && !prev_valid) rise_time = $time;
        if (code_if.code_valid && code_if.code_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(code_if.code_data), 32'(e));
          end
        end
        prev_valid = code_if.code_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 code_if.code_ready = v;
  endtask

  task automatic send_bit(input logic b);
    repeat (10) @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    t_fall  = $time;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    repeat (20) @(negedge clk);
  endtask

  // Start bit plus the first nbits-1 data bits of 0xFF, line left idle-high clock.
  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 1; i < nbits; i++) send_bit(1'b1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  initial begin
    int e0;
    int v0;
    int lat;
    code_if.code_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(code_if.code_valid), 32'd0);
    check("rst_data", 32'(code_if.code_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single good frame, latency and one-cycle valid pulse
    set_ready(1'b1);
    e0 = err_cnt;
    v0 = valid_hi;
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0);
    lat = int'((rise_time - t_fall) / 10);
    check("t1_latency_9pm1", 32'((lat >= 8) && (lat <= 10)), 32'd1);
    check("t1_valid_cycles", 32'(valid_hi - v0), 32'd1);
    check("t1_no_ferr", 32'(err_cnt - e0), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Bad parity, then good frame
    e0 = err_cnt;
    v0 = valid_hi;
    send_frame(8'h1C, 1'b1);
    check("t2_ferr", 32'(err_cnt - e0), 32'd1);
    check("t2_no_valid", 32'(valid_hi - v0), 32'd0);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Prefix sequences
`ifdef PS2_PREFIX_FOLD_EN
    exp_q.push_back(10'h175);
    exp_q.push_back(10'h375);
`else
    exp_q.push_back(10'h0E0);
    exp_q.push_back(10'h075);
    exp_q.push_back(10'h0E0);
    exp_q.push_back(10'h0F0);
    exp_q.push_back(10'h075);
`endif
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: 9 frames into an 8-deep FIFO, the 9th is dropped
    set_ready(1'b0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(10'(i));
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    check("t4_valid_full", 32'(code_if.code_valid), 32'd1);
    check("t4_ovf_set", 32'(overflow), 32'd1);
    set_ready(1'b1);
    wait_drain(40);
    repeat (5) @(negedge clk);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_valid_empty", 32'(code_if.code_valid), 32'd0);
    check("t4_ovf_still_set", 32'(overflow), 32'd1);
    @(posedge clk);
    #1 ovf_clear = 1'b1;
    @(posedge clk);
    #1 ovf_clear = 1'b0;
    @(negedge clk);
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // Timeout after start + 4 data bits
    e0 = err_cnt;
    send_partial(5);
    for (int i = 0; i < TO_CYC + 5000 && err_cnt == e0; i++) @(negedge clk);
    check("t5_timeout_ferr", 32'(err_cnt - e0), 32'd1);
    lat = int'((err_time - t_fall) / 10);
    check("t5_timeout_window",
          32'((lat >= TO_CYC - FLEN - 4) && (lat <= TO_CYC + FLEN + 4)), 32'd1);
    exp_q.push_back(10'h05A);
    send_frame(8'h5A, 1'b0);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with two entries queued
    set_ready(1'b0);
    exp_q.push_back(10'h011);
    exp_q.push_back(10'h022);
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    check("t6_valid_before", 32'(code_if.code_valid), 32'd1);
    send_partial(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(code_if.code_valid), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_data", 32'(code_if.code_data), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    ps2_data = 1'b1;
    rst_n    = 1'b1;
    set_ready(1'b1);
    exp_q.push_back(10'h029);
    send_frame(8'h29, 1'b0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (10) @(negedge clk);
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ps2_rx
